// File: rtl/gnr_ctrl.sv
// Sequencer for a network of step-driven nodes: loads initial state, issues s0/s1 step
// strobes, captures the s1 state after each step and hands it out over a valid/ready port.
module gnr_ctrl #(
    parameter int N_NODES = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_state_in,
    input  logic [CNT_W-1:0]   num_steps,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] cgc_s0,
    input  logic [N_NODES-1:0] cgc_s1,
    output logic [N_NODES-1:0] state_data,
    output logic [CNT_W-1:0]   state_idx,
    output logic               state_valid,
    input  logic               state_ready,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STEP0  = 3'd2;
    localparam logic [2:0] S_STEP1  = 3'd3;
    localparam logic [2:0] S_SAMPLE = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]         state_q, state_d;
    logic [N_NODES-1:0] init_q;
    logic [N_NODES-1:0] data_q;
    logic [CNT_W-1:0]   steps_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   idx_q;

    // cgc_s0 only feeds the debug readback path, which this block does not implement.
    logic unused_cgc_s0;
    assign unused_cgc_s0 = ^cgc_s0;

    always_comb begin
        // NOTE: default assignment first, so no branch can leave state_d unassigned and infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD:   state_d = (steps_q == '0) ? S_DONE : S_STEP0;
            S_STEP0:  state_d = S_STEP1;
            S_STEP1:  state_d = S_SAMPLE;
            S_SAMPLE: state_d = S_OUT;
            S_OUT:    if (state_ready) state_d = (cnt_q == steps_q) ? S_DONE : S_STEP0;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            init_q  <= '0;
            steps_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                init_q  <= init_state_in;
                steps_q <= num_steps;
                cnt_q   <= '0;
            end
            // Counter stops at steps_q, so it cannot wrap even for the all-ones step count.
            if (state_q == S_STEP1) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (state_q == S_SAMPLE) begin
                data_q <= cgc_s1;
                idx_q  <= cnt_q;
            end
        end
    end

    assign reset_nos   = (state_q == S_LOAD);
    assign start_s0    = (state_q == S_STEP0);
    assign start_s1    = (state_q == S_STEP1);
    assign state_valid = (state_q == S_OUT);
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign init_state  = init_q;
    assign state_data  = data_q;
    assign state_idx   = idx_q;

endmodule

// File: tb/tb_gnr_ctrl.sv
// Bench for gnr_ctrl: a behavioural node model, a scoreboard of expected outputs,
// a table of run scenarios plus hand-written latency and reset sequences.
module tb_gnr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  init_state_in;
    logic [15:0] num_steps;
    logic        reset_nos;
    logic [7:0]  init_state;
    logic        start_s0;
    logic        start_s1;
    logic [7:0]  cgc_s0;
    logic [7:0]  cgc_s1;
    logic [7:0]  state_data;
    logic [15:0] state_idx;
    logic        state_valid;
    logic        state_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    gnr_ctrl #(.N_NODES(8), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .init_state_in (init_state_in),
        .num_steps     (num_steps),
        .reset_nos     (reset_nos),
        .init_state    (init_state),
        .start_s0      (start_s0),
        .start_s1      (start_s1),
        .cgc_s0        (cgc_s0),
        .cgc_s1        (cgc_s1),
        .state_data    (state_data),
        .state_idx     (state_idx),
        .state_valid   (state_valid),
        .state_ready   (state_ready),
        .busy          (busy),
        .done          (done)
    );

    // Node model: loads on reset_nos, optionally counts up on every s1 strobe.
    logic [7:0] node;
    bit         node_incr;
    always @(posedge clk) begin
        if (reset_nos) node <= init_state;
        else if (start_s1 && node_incr) node <= node + 8'd1;
    end
    assign cgc_s1 = node;
    assign cgc_s0 = ~node;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] idx;
    } exp_t;

    typedef struct {
        logic [7:0]  init;
        logic [15:0] steps;
        bit          incr;
        int          stall;
        bit          rnd;
        bit          restart;
        int          exp_outs;
        int          exp_s0;
    } vec_t;

    typedef struct {
        logic [5:0] flags; // {reset_nos, start_s0, start_s1, state_valid, done, busy}
    } row_t;

    exp_t sb[$];
    vec_t vecs[7];
    row_t rows[7];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int out_cnt, done_cnt, s0_cnt, s1_cnt, rn_cnt, val_cnt, rn_cyc, done_cyc;
    logic        prev_valid, prev_hs;
    logic [7:0]  prev_data;
    logic [15:0] prev_idx, last_idx;

    task check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task clear_mon();
        out_cnt = 0; done_cnt = 0; s0_cnt = 0; s1_cnt = 0; rn_cnt = 0; val_cnt = 0;
        rn_cyc = 0; done_cyc = 0; last_idx = 16'd0; prev_valid = 1'b0; prev_hs = 1'b0;
        sb.delete();
    endtask

    task monitor();
        exp_t e;
        logic hs;
        if (rst !== 1'b0) begin
            prev_valid = 1'b0;
            return;
        end
        check("strobe_mutex", 32'($countones({reset_nos, start_s0, start_s1, state_valid}) > 1), 32'd0);
        if (reset_nos) begin rn_cnt++; rn_cyc = cyc; end
        if (start_s0) s0_cnt++;
        if (start_s1) s1_cnt++;
        if (state_valid) val_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (state_valid && prev_valid && !prev_hs) begin
            check("hold_data", 32'(state_data), 32'(prev_data));
            check("hold_idx", 32'(state_idx), 32'(prev_idx));
        end
        hs = state_valid && state_ready;
        if (hs) begin
            out_cnt++;
            check("idx_step", 32'(state_idx), 32'(last_idx) + 32'd1);
            last_idx = state_idx;
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_data", 32'(state_data), 32'(e.data));
                check("sb_idx", 32'(state_idx), 32'(e.idx));
            end
        end
        prev_valid = state_valid;
        prev_hs    = hs;
        prev_data  = state_data;
        prev_idx   = state_idx;
    endtask

    // One clock: sample outputs at the falling edge, then step past the rising edge.
    task tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task run_vec(input vec_t v);
        exp_t e;
        int   k, stall_left, budget;
        bit   seen;
        clear_mon();
        node_incr = v.incr;
        for (int i = 1; i <= int'(v.steps); i++) begin
            e.data = v.init + (v.incr ? 8'(i) : 8'd0);
            e.idx  = 16'(i);
            sb.push_back(e);
        end
        init_state_in = v.init;
        num_steps     = v.steps;
        state_ready   = 1'b1;
        start         = 1'b1;
        tick();
        start = 1'b0;
        k = 1; stall_left = 0; seen = 1'b0;
        budget = 60 + 30 * int'(v.steps);
        while (done_cnt == 0 && k < budget) begin
            if (v.restart && k == 3) begin
                start         = 1'b1;
                init_state_in = ~v.init;
                num_steps     = 16'd7;
            end else begin
                start = 1'b0;
            end
            if (state_valid && !seen) begin
                seen       = 1'b1;
                stall_left = v.stall;
            end
            if (v.rnd) state_ready = 1'($urandom_range(0, 1));
            else       state_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            tick();
            k++;
        end
        start       = 1'b0;
        state_ready = 1'b1;
        check("done_seen", 32'(done_cnt > 0), 32'd1);
        repeat (3) tick();
        check("outputs", 32'(out_cnt), 32'(v.exp_outs));
        check("s0_count", 32'(s0_cnt), 32'(v.exp_s0));
        check("s1_count", 32'(s1_cnt), 32'(v.exp_s0));
        check("load_count", 32'(rn_cnt), 32'd1);
        check("done_count", 32'(done_cnt), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
        if (v.steps == 16'd0) begin
            check("zero_done_gap", 32'(done_cyc - rn_cyc), 32'd1);
            check("zero_no_valid", 32'(val_cnt), 32'd0);
        end
    endtask

    initial begin
        exp_t e;
        int   k;

        //            init    steps   incr stall rnd  rst  outs s0
        vecs[0] = '{8'hA5, 16'd1,  1'b0, 0, 1'b0, 1'b0, 1,  1};
        vecs[1] = '{8'h00, 16'd0,  1'b0, 0, 1'b0, 1'b0, 0,  0};
        vecs[2] = '{8'h3C, 16'd3,  1'b1, 4, 1'b0, 1'b0, 3,  3};
        vecs[3] = '{8'h5A, 16'd2,  1'b0, 0, 1'b0, 1'b1, 2,  2};
        vecs[4] = '{8'hF0, 16'd6,  1'b1, 0, 1'b1, 1'b0, 6,  6};
        vecs[5] = '{8'hFE, 16'd4,  1'b1, 0, 1'b0, 1'b0, 4,  4};
        vecs[6] = '{8'h81, 16'd10, 1'b1, 0, 1'b1, 1'b0, 10, 10};

        // Timeline after start accepted at cycle t, rows for t+1 .. t+7.
        rows[0].flags = 6'b100001;
        rows[1].flags = 6'b010001;
        rows[2].flags = 6'b001001;
        rows[3].flags = 6'b000001;
        rows[4].flags = 6'b000101;
        rows[5].flags = 6'b000011;
        rows[6].flags = 6'b000000;

        clear_mon();
        node_incr     = 1'b0;
        rst           = 1'b1;
        start         = 1'b1;
        init_state_in = 8'hFF;
        num_steps     = 16'd3;
        state_ready   = 1'b1;
        tick();
        tick();
        check("reset_flags", 32'({reset_nos, start_s0, start_s1, state_valid, done, busy}), 32'd0);
        check("reset_init_state", 32'(init_state), 32'd0);
        check("reset_state_data", 32'(state_data), 32'd0);
        check("reset_state_idx", 32'(state_idx), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("rst_over_start", 32'(busy), 32'd0);

        // Exact cycle-by-cycle timeline of a one-step run.
        clear_mon();
        e.data = 8'hA5; e.idx = 16'd1;
        sb.push_back(e);
        init_state_in = 8'hA5;
        num_steps     = 16'd1;
        start         = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 7; r++) begin
            check($sformatf("timeline_t+%0d", r + 1),
                  32'({reset_nos, start_s0, start_s1, state_valid, done, busy}), 32'(rows[r].flags));
            if (r == 0) check("load_init_state", 32'(init_state), 32'hA5);
            if (r == 4) begin
                check("first_data", 32'(state_data), 32'hA5);
                check("first_idx", 32'(state_idx), 32'd1);
            end
            tick();
        end
        check("timeline_sb_empty", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset while an output is pending: discarded, no done, then a clean run.
        clear_mon();
        node_incr     = 1'b0;
        init_state_in = 8'h96;
        num_steps     = 16'd2;
        state_ready   = 1'b0;
        start         = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!state_valid && k < 20) begin tick(); k++; end
        check("reach_out", 32'(state_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_flags", 32'({reset_nos, start_s0, start_s1, state_valid, done, busy}), 32'd0);
        check("abort_init_state", 32'(init_state), 32'd0);
        check("abort_state_data", 32'(state_data), 32'd0);
        check("abort_state_idx", 32'(state_idx), 32'd0);
        clear_mon();
        state_ready = 1'b1;
        repeat (5) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_no_strobes", 32'(s0_cnt + s1_cnt + rn_cnt + val_cnt), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        run_vec(vecs[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gnr_ctrl.md
GNR_CTRL -- requirements
Module: gnr_ctrl

Interface
REQ-001 Parameter N_NODES, default 8: number of network nodes driven; width of all node-state vectors.
REQ-002 Parameter CNT_W, default 16: width of step count and step index.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 init_state_in  input  N_NODES  initial node states; latched when start is accepted.
REQ-007 num_steps  input  CNT_W  number of s0/s1 step pairs to run; latched when start is accepted.
REQ-008 reset_nos  output  1  node load strobe, broadcast to all nodes.
REQ-009 init_state  output  N_NODES  per-node initial state; bit i drives node i.
REQ-010 start_s0  output  1  node phase-0 step strobe.
REQ-011 start_s1  output  1  node phase-1 step strobe.
REQ-012 cgc_s0  input  N_NODES  node s0 state vector; bit i comes from node i.
REQ-013 cgc_s1  input  N_NODES  node s1 state vector; bit i comes from node i.
REQ-014 state_data  output  N_NODES  captured network state.
REQ-015 state_idx  output  CNT_W  1-based step number of state_data.
REQ-016 state_valid  output  1  state_data/state_idx valid.
REQ-017 state_ready  input  1  consumer accepts the current output.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse at end of run.

Function
REQ-020 FSM states: IDLE, LOAD, STEP0, STEP1, SAMPLE, OUT, DONE; all outputs are registered or decoded from state.
REQ-021 IDLE, start=1 -> latch init_state_in and num_steps, clear step counter, go to LOAD.
REQ-022 LOAD: reset_nos=1 for exactly one cycle with init_state = latched value.
- If latched num_steps=0, next state is DONE.
- Otherwise, next state is STEP0.
REQ-023 STEP0: start_s0=1 for one cycle, then STEP1.
REQ-024 STEP1: start_s1=1 for one cycle, increment step counter, then SAMPLE.
REQ-025 SAMPLE: register cgc_s1 into state_data and step counter into state_idx, then OUT.
REQ-026 OUT: state_valid=1; data and index are held stable until state_valid & state_ready.
- On handshake with counter == num_steps: go to DONE.
- On handshake otherwise: go to STEP0.
REQ-027 state_ready low in OUT stalls the run: no strobes are issued and the node states stay untouched.
REQ-028 DONE: done=1 for one cycle, then IDLE.
REQ-029 reset_nos, start_s0, start_s1 and state_valid are mutually exclusive; at most one is high per cycle.
REQ-030 start while busy=1 is ignored; latched values do not change.
REQ-031 Latency:
- start accepted at cycle t -> reset_nos at t+1, start_s0 at t+2, start_s1 at t+3, state_valid first high at t+5.
- Each further step, after a handshake at cycle u -> start_s0 at u+1, state_valid at u+4.
REQ-032 num_steps = 2^CNT_W-1 is supported; the step counter never wraps within a run.
REQ-033 state_ready is ignored outside OUT.
REQ-034 cgc_s0 is unused by the sequencing logic; it is reserved for the debug readback port.

Reset
REQ-035 rst=1 forces IDLE and clears all outputs to 0 on the next edge: reset_nos, init_state, start_s0, start_s1, state_data, state_idx, state_valid, busy, done.
REQ-036 rst also clears the latched init value, the latched num_steps and the step counter.
REQ-037 rst mid-run aborts immediately:
- no further strobes are issued;
- a pending output is discarded;
- done is not pulsed.
REQ-038 rst has priority over start in the same cycle.

Verification
REQ-039 N_NODES=8: init_state_in=0xA5, num_steps=1, state_ready=1, nodes hold state.
- Expect reset_nos with init_state=0xA5 at t+1, start_s0 at t+2, start_s1 at t+3.
- Expect state_valid at t+5 with state_data=0xA5, state_idx=1.
- Expect done at t+6; busy low at t+7.
REQ-040 num_steps=0: expect reset_nos one cycle, done the cycle after, no start_s0, start_s1 or state_valid.
REQ-041 num_steps=3, state_ready low for 4 cycles after the first state_valid.
- Expect state_valid and data held, no strobes during the stall.
- Expect exactly 3 outputs with state_idx 1, 2, 3.
REQ-042 start pulsed during STEP1 of a run with num_steps=2: ignored; the run completes with 2 outputs and one done.
REQ-043 rst asserted in OUT with state_valid=1: next cycle all outputs are 0 and the FSM is in IDLE; a new start then runs normally.
REQ-044 Random stimulus: check the strobe mutual exclusion of REQ-029 every cycle; check state_idx increments by 1 per handshake.
